// File: rtl/anthem_pkg.sv
// Shared anthem stream definitions: phrase ROM contents, sync pattern and checker states.
// Both the transmit and receive ends import this so the phrase is defined once.
package anthem_pkg;

  localparam int unsigned FRAME_LEN = 51;

  localparam logic [7:0] SYNC_B0 = 8'h61;  // 'a' at position 49
  localparam logic [7:0] SYNC_B1 = 8'h20;  // ' ' at position 50
  localparam logic [7:0] SYNC_B2 = 8'h54;  // 'T' at position 0

  // First character sits in the most significant byte.
  localparam logic [8*FRAME_LEN-1:0] PHRASE =
    "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } state_e;

  function automatic logic [7:0] phrase_byte(input logic [5:0] idx);
    int unsigned i;
    i = 32'(idx);
    if (i < FRAME_LEN) begin
      return PHRASE[8*(FRAME_LEN-1-i) +: 8];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/anthem_rom.sv
// Combinational phrase lookup: position -> expected byte, 0x00 beyond the frame.
module anthem_rom
  import anthem_pkg::*;
(
  input  logic [5:0] i_idx,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = phrase_byte(i_idx);
  end

endmodule

// File: rtl/anthem_stream_checker.sv
// Receive-side anthem stream checker: hunts for the frame boundary, verifies one frame,
// then tracks lock while counting byte errors and clean frames.
module anthem_stream_checker
  import anthem_pkg::*;
#(
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic [7:0]       i_in_data,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_frame_ok,
  output logic             o_mismatch,
  output logic [ERR_W-1:0] o_err_count,
  output logic [ERR_W-1:0] o_frame_count
);

  localparam logic [5:0] LastIdx = 6'(FRAME_LEN - 1);

  state_e           r_state, w_state_nxt;
  logic [5:0]       r_idx, w_idx_nxt;
  logic [15:0]      r_hist, w_hist_nxt;
  logic [3:0]       r_bad, w_bad_nxt;
  logic             r_clean, w_clean_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_frame_ok, w_frame_ok_nxt;
  logic             r_mismatch, w_mismatch_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic [ERR_W-1:0] r_fcnt, w_fcnt_nxt;

  logic [7:0] w_rom_byte;
  logic       w_match;
  logic       w_last;
  logic [3:0] w_bad_inc;
  logic       w_err_inc;
  logic       w_fcnt_inc;

  anthem_rom u_rom (
    .i_idx  (r_idx),
    .o_byte (w_rom_byte)
  );

  assign w_match   = (i_in_data == w_rom_byte);
  assign w_last    = (r_idx == LastIdx);
  assign w_bad_inc = r_bad + 4'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_hist_nxt     = r_hist;
    w_bad_nxt      = r_bad;
    w_clean_nxt    = r_clean;
    w_frame_ok_nxt = 1'b0;
    w_mismatch_nxt = 1'b0;
    w_err_inc      = 1'b0;
    w_fcnt_inc     = 1'b0;

    if (i_in_valid) begin
      unique case (r_state)
        StHunt: begin
          w_hist_nxt = {r_hist[7:0], i_in_data};
          if (r_hist == {SYNC_B0, SYNC_B1} && i_in_data == SYNC_B2) begin
            w_state_nxt = StVerify;
            w_idx_nxt   = 6'd1;
          end
        end

        StVerify: begin
          if (!w_match) begin
            w_state_nxt = StHunt;
            w_idx_nxt   = 6'd0;
            w_hist_nxt  = 16'h0000;
          end else if (w_last) begin
            w_state_nxt    = StLocked;
            w_idx_nxt      = 6'd0;
            w_bad_nxt      = 4'd0;
            w_clean_nxt    = 1'b1;
            w_frame_ok_nxt = 1'b1;
            w_fcnt_inc     = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 6'd1;
          end
        end

        StLocked: begin
          if (!w_match) begin
            w_mismatch_nxt = 1'b1;
            w_err_inc      = 1'b1;
            w_bad_nxt      = w_bad_inc;
            w_clean_nxt    = 1'b0;
          end else begin
            w_bad_nxt = 4'd0;
          end

          // Loss of lock takes priority over a frame_ok on the closing byte.
          if (!w_match && w_bad_inc == 4'(LOSS_THRESH)) begin
            w_state_nxt = StHunt;
            w_idx_nxt   = 6'd0;
            w_hist_nxt  = 16'h0000;
            w_bad_nxt   = 4'd0;
            w_clean_nxt = 1'b1;
          end else if (w_last) begin
            w_idx_nxt   = 6'd0;
            w_clean_nxt = 1'b1;
            if (r_clean && w_match) begin
              w_frame_ok_nxt = 1'b1;
              w_fcnt_inc     = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx + 6'd1;
          end
        end

        default: begin
          w_state_nxt = StHunt;
          w_idx_nxt   = 6'd0;
          w_hist_nxt  = 16'h0000;
        end
      endcase
    end

    w_locked_nxt = (w_state_nxt == StLocked);

    if (i_clear) begin
      w_err_nxt = '0;
    end else if (w_err_inc && r_err != '1) begin
      w_err_nxt = r_err + ERR_W'(1);
    end else begin
      w_err_nxt = r_err;
    end

    if (i_clear) begin
      w_fcnt_nxt = '0;
    end else if (w_fcnt_inc) begin
      w_fcnt_nxt = r_fcnt + ERR_W'(1);
    end else begin
      w_fcnt_nxt = r_fcnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StHunt;
      r_idx      <= 6'd0;
      r_hist     <= 16'h0000;
      r_bad      <= 4'd0;
      r_clean    <= 1'b1;
      r_locked   <= 1'b0;
      r_frame_ok <= 1'b0;
      r_mismatch <= 1'b0;
      r_err      <= '0;
      r_fcnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_hist     <= w_hist_nxt;
      r_bad      <= w_bad_nxt;
      r_clean    <= w_clean_nxt;
      r_locked   <= w_locked_nxt;
      r_frame_ok <= w_frame_ok_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_err      <= w_err_nxt;
      r_fcnt     <= w_fcnt_nxt;
    end
  end

  assign o_locked      = r_locked;
  assign o_frame_ok    = r_frame_ok;
  assign o_mismatch    = r_mismatch;
  assign o_err_count   = r_err;
  assign o_frame_count = r_fcnt;

endmodule
